// File: rtl/div_seq.sv
// -----------------------------------------------------------------------------
// div_seq -- iterative radix-2 restoring divider for DIV/DIVU in EX.
//
// The divider latches the operand magnitudes and sign bits when EX presents a
// request. It produces one quotient bit per cycle for WIDTH cycles. It then
// holds the sign-corrected quotient (to LO) and remainder (to HI) until the
// instruction leaves EX.
//
// Ports
//   clk          clock
//   reset        asynchronous, active-high reset
//   div_req      EX holds a valid DIV/DIVU
//   div_signed   1 = DIV, 0 = DIVU (sampled with div_req in IDLE)
//   src1, src2   dividend, divisor
//   es_go        EX instruction leaves EX this cycle (result consumed)
//   flush        exception/ERET flush of EX; abandons any operation
//   div_stop     EX must stall (request cycle plus every BUSY cycle)
//   div_busy     sequencer is not IDLE
//   result_valid quotient/remainder valid (DONE)
//   quotient     signed/unsigned quotient, registered
//   remainder    signed/unsigned remainder, registered
// -----------------------------------------------------------------------------
module div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             div_req,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic             es_go,
  input  logic             flush,
  output logic             div_stop,
  output logic             div_busy,
  output logic             result_valid,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  // The dividend shifts out of the MSB while quotient bits shift into the LSB.
  // After WIDTH steps this register therefore holds the quotient magnitude.
  logic [WIDTH-1:0] dvd_q,   dvd_d;
  logic [WIDTH-1:0] dsr_q,   dsr_d;
  logic [WIDTH-1:0] rem_q,   rem_d;
  logic             sign1_q, sign1_d;
  logic             sign2_q, sign2_d;
  logic [WIDTH-1:0] quo_q,   quo_d;
  logic [WIDTH-1:0] rmd_q,   rmd_d;

  logic [WIDTH-1:0] abs1, abs2;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   diff;
  logic             q_bit;
  logic [WIDTH-1:0] q_next, r_next;
  logic             last_iter;
  logic             start;

  // Magnitudes of the operands. The most negative value maps to itself and is
  // then read as the unsigned 2^(WIDTH-1).
  assign abs1 = (div_signed && src1[WIDTH-1]) ? -src1 : src1;
  assign abs2 = (div_signed && src2[WIDTH-1]) ? -src2 : src2;

  // The shifted partial remainder is kept WIDTH+1 bits wide. Divisors of
  // 2^(WIDTH-1) or more can leave a partial remainder whose top bit is set, and
  // that bit must survive the shift. The subtractor borrow then gives the
  // quotient bit directly.
  assign rem_shift = {rem_q, dvd_q[WIDTH-1]};
  assign diff      = rem_shift - {1'b0, dsr_q};
  assign q_bit     = ~diff[WIDTH];
  assign r_next    = q_bit ? diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
  assign q_next    = {dvd_q[WIDTH-2:0], q_bit};
  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));
  assign start     = div_req && !flush;

  always_comb begin
    // NOTE: every signal assigned in this block receives a default first, so a
    // path that skips an assignment cannot infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    rem_d   = rem_q;
    sign1_d = sign1_q;
    sign2_d = sign2_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          dvd_d   = abs1;
          dsr_d   = abs2;
          sign1_d = div_signed & src1[WIDTH-1];
          sign2_d = div_signed & src2[WIDTH-1];
          rem_d   = '0;
          cnt_d   = '0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        dvd_d = q_next;
        rem_d = r_next;
        cnt_d = cnt_q + CNT_W'(1);
        if (flush) begin
          state_d = S_IDLE;
        end else if (last_iter) begin
          // Apply the sign correction while loading the output registers, so
          // the DONE outputs come straight from flops.
          quo_d   = (sign1_q ^ sign2_q) ? -q_next : q_next;
          rmd_d   = sign1_q ? -r_next : r_next;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // div_req is still high here because the same instruction is in EX.
        // Only consumption or a flush releases the result.
        if (es_go || flush) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      rem_q   <= '0;
      sign1_q <= 1'b0;
      sign2_q <= 1'b0;
      quo_q   <= '0;
      rmd_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments. Every register
      // then samples its pre-edge value, and the order of these lines does not
      // matter.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      rem_q   <= rem_d;
      sign1_q <= sign1_d;
      sign2_q <= sign2_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
    end
  end

  // The request-cycle stall is combinational, so EX stalls in the same cycle
  // that it presents the division.
  always_comb begin
    div_stop = 1'b0;
    case (state_q)
      S_IDLE:  div_stop = start;
      S_BUSY:  div_stop = 1'b1;
      default: div_stop = 1'b0;
    endcase
  end

  assign div_busy     = (state_q != S_IDLE);
  assign result_valid = (state_q == S_DONE);
  assign quotient     = quo_q;
  assign remainder    = rmd_q;

endmodule

// File: tb/tb_div_seq.sv
// -----------------------------------------------------------------------------
// tb_div_seq -- self-checking bench for div_seq (WIDTH = 32).
// Each operation pushes its expected quotient and remainder into a scoreboard
// queue when the request is driven. The entry is popped and compared when
// result_valid rises.
// -----------------------------------------------------------------------------
module tb_div_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         div_req;
  logic         div_signed;
  logic [W-1:0] src1;
  logic [W-1:0] src2;
  logic         es_go;
  logic         flush;
  logic         div_stop;
  logic         div_busy;
  logic         result_valid;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  div_seq #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .div_req      (div_req),
    .div_signed   (div_signed),
    .src1         (src1),
    .src2         (src2),
    .es_go        (es_go),
    .flush        (flush),
    .div_stop     (div_stop),
    .div_busy     (div_busy),
    .result_valid (result_valid),
    .quotient     (quotient),
    .remainder    (remainder)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model built on magnitudes and the language's own divide/modulo.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    exp_t         e;
    logic         s1, s2;
    logic [W-1:0] ma, mb, mq, mr;
    s1 = s & a[W-1];
    s2 = s & b[W-1];
    ma = s1 ? -a : a;
    mb = s2 ? -b : b;
    if (mb == '0) begin
      mq = '1;
      mr = ma;
    end else begin
      mq = ma / mb;
      mr = ma % mb;
    end
    e.q = (s1 ^ s2) ? -mq : mq;
    e.r = s1 ? -mr : mr;
    return e;
  endfunction

  // Run one division. Request is driven in the current cycle, es_go is held off
  // for 'hold' cycles in DONE (with div_req still high), then the result is
  // consumed and the DUT must be back in IDLE.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input logic [W-1:0] eq, input logic [W-1:0] er, input int hold);
    exp_t e;
    int   cyc;
    bit   timed_out;
    e.q = eq;
    e.r = er;
    src1       = a;
    src2       = b;
    div_signed = s;
    div_req    = 1'b1;
    sb.push_back(e);
    #1;
    check("stop_req_cycle", div_stop, 1'b1);
    cyc       = 0;
    timed_out = 0;
    forever begin
      tick();
      cyc++;
      if (result_valid === 1'b1) break;
      check("stop_busy", div_stop, 1'b1);
      if (cyc >= W + 8) begin
        timed_out = 1;
        break;
      end
    end
    check("latency", cyc, W + 1);
    e = sb.pop_front();
    if (!timed_out) begin
      check("quotient", quotient, e.q);
      check("remainder", remainder, e.r);
      check("stop_done", div_stop, 1'b0);
      for (int i = 0; i < hold; i++) begin
        tick();
        check("hold_valid", result_valid, 1'b1);
        check("hold_quotient", quotient, e.q);
        check("hold_remainder", remainder, e.r);
        check("hold_stop", div_stop, 1'b0);
      end
    end
    es_go = 1'b1;
    tick();
    es_go   = 1'b0;
    div_req = 1'b0;
    #1;
    check("idle_busy", div_busy, 1'b0);
    check("idle_valid", result_valid, 1'b0);
    check("idle_stop", div_stop, 1'b0);
  endtask

  initial begin
    exp_t         m;
    logic [W-1:0] ra, rb;
    logic         rs;

    reset      = 1'b1;
    div_req    = 1'b0;
    div_signed = 1'b0;
    src1       = '0;
    src2       = '0;
    es_go      = 1'b0;
    flush      = 1'b0;
    #12;
    check("rst_stop", div_stop, 1'b0);
    check("rst_busy", div_busy, 1'b0);
    check("rst_valid", result_valid, 1'b0);
    check("rst_quotient", quotient, '0);
    check("rst_remainder", remainder, '0);
    reset = 1'b0;
    tick();

    // Directed cases with hand-derived results.
    run_op(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 0);
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0);
    run_op(32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 0);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 0);
    run_op(32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd5, 0);
    // DONE held for 5 cycles with div_req high, then a back-to-back DIVU whose
    // divisor has its top bit set.
    run_op(32'd1000, 32'd33, 1'b0, 32'd30, 32'd10, 5);
    run_op(32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 32'd1, 32'h7FFF_FFFF, 0);
    // A signed dividend against DIVU: the operands stay unsigned.
    run_op(32'hFFFF_FFF9, 32'd2, 1'b0, 32'h7FFF_FFFC, 32'd1, 1);

    // Random operations checked against the reference model.
    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 28);
      rs = 1'($urandom_range(0, 1));
      m  = model(ra, rb, rs);
      run_op(ra, rb, rs, m.q, m.r, 0);
    end

    // Flush in BUSY cycle 10. The DUT must abandon the operation and never
    // raise result_valid for it.
    src1       = 32'd100;
    src2       = 32'd7;
    div_signed = 1'b0;
    div_req    = 1'b1;
    #1;
    repeat (10) tick();
    check("flush_pre_busy", div_busy, 1'b1);
    flush = 1'b1;
    tick();
    flush   = 1'b0;
    div_req = 1'b0;
    #1;
    check("flush_busy", div_busy, 1'b0);
    check("flush_stop", div_stop, 1'b0);
    check("flush_valid", result_valid, 1'b0);
    tick();
    check("flush_valid_later", result_valid, 1'b0);
    run_op(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 0);

    // Flush beats a simultaneous request in IDLE.
    div_req = 1'b1;
    flush   = 1'b1;
    #1;
    check("flush_req_stop", div_stop, 1'b0);
    tick();
    check("flush_req_busy", div_busy, 1'b0);
    flush   = 1'b0;
    div_req = 1'b0;

    // Asynchronous reset between clock edges in the middle of BUSY.
    src1       = 32'h1234_5678;
    src2       = 32'd9;
    div_signed = 1'b0;
    div_req    = 1'b1;
    #1;
    repeat (6) tick();
    #3;
    reset   = 1'b1;
    div_req = 1'b0;
    #1;
    check("async_rst_busy", div_busy, 1'b0);
    check("async_rst_stop", div_stop, 1'b0);
    check("async_rst_valid", result_valid, 1'b0);
    check("async_rst_quotient", quotient, '0);
    check("async_rst_remainder", remainder, '0);
    #1;
    reset = 1'b0;
    tick();
    run_op(32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 0);

    check("scoreboard_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
